// File: rtl/i2s_dac_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2s_dac_serializer_if                                           |
// | Function : sample-capture and I2S-output signal bundle for the serializer  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface i2s_dac_serializer_if #(
  parameter int DATA_BITS = 24
);
  logic                 run;
  logic                 l_din_valid;
  logic                 r_din_valid;
  logic [DATA_BITS-1:0] l_din;
  logic [DATA_BITS-1:0] r_din;
  logic                 bclk;
  logic                 lrclk;
  logic                 sdata;
  logic                 frame_start;
  logic                 underrun;
  logic                 overrun;
  logic [15:0]          test_data;

  modport master (
    output run, l_din_valid, r_din_valid, l_din, r_din,
    input  bclk, lrclk, sdata, frame_start, underrun, overrun, test_data
  );

  modport slave (
    input  run, l_din_valid, r_din_valid, l_din, r_din,
    output bclk, lrclk, sdata, frame_start, underrun, overrun, test_data
  );
endinterface
`default_nettype wire

// File: rtl/i2s_dac_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2s_dac_serializer                                              |
// | Function : pairs L/R samples, double-buffers them, emits I2S frames        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module i2s_dac_serializer #(
  parameter int BCLK_DIV  = 8,
  parameter int SLOT_BITS = 32,
  parameter int DATA_BITS = 24
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  i2s_dac_serializer_if.slave   bus
);
  localparam int c_FRAME_BITS = 2 * SLOT_BITS;
  localparam int c_DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int c_BIT_W      = $clog2(c_FRAME_BITS);
  localparam int c_IDX_W      = $clog2(DATA_BITS);

  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BCLK_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(BCLK_DIV / 2);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_FRAME_BITS - 1);
  localparam logic [c_BIT_W-1:0] c_SLOT     = c_BIT_W'(SLOT_BITS);
  localparam logic [c_BIT_W-1:0] c_DATA     = c_BIT_W'(DATA_BITS);

  logic                 r_active;
  logic [c_DIV_W-1:0]   r_div_cnt;
  logic [c_BIT_W-1:0]   r_bit_cnt;
  logic                 r_l_pend;
  logic                 r_r_pend;
  logic [DATA_BITS-1:0] r_l_pend_data;
  logic [DATA_BITS-1:0] r_r_pend_data;
  logic [DATA_BITS-1:0] r_l_held;
  logic [DATA_BITS-1:0] r_r_held;
  logic [7:0]           r_underrun_cnt;
  logic                 r_bclk;
  logic                 r_lrclk;
  logic                 r_sdata;
  logic                 r_frame_start;
  logic                 r_underrun;
  logic                 r_overrun;

  logic                 w_div_wrap;
  logic                 w_load;
  logic                 w_pair;
  logic                 w_l_over;
  logic                 w_r_over;
  logic                 w_right;
  logic                 w_sdata_nxt;
  logic [c_DIV_W-1:0]   w_div_nxt;
  logic [c_BIT_W-1:0]   w_bit_nxt;
  logic [c_BIT_W-1:0]   w_slot;
  logic [c_IDX_W-1:0]   w_idx;
  logic [DATA_BITS-1:0] w_sample;

  assign w_div_wrap = (r_div_cnt == c_DIV_LAST);
  assign w_load     = r_active && w_div_wrap && (r_bit_cnt == c_BIT_LAST);
  assign w_pair     = r_l_pend && r_r_pend;
  assign w_l_over   = bus.l_din_valid && r_l_pend && !w_load;
  assign w_r_over   = bus.r_din_valid && r_r_pend && !w_load;

  // The first enabled clk only arms the timing; counters then leave (0,0).
  always_comb begin
    w_div_nxt = '0;
    w_bit_nxt = '0;
    if (r_active) begin
      if (w_div_wrap) begin
        w_div_nxt = '0;
        w_bit_nxt = (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
      end else begin
        w_div_nxt = r_div_cnt + 1'b1;
        w_bit_nxt = r_bit_cnt;
      end
    end
  end

  // Output registers track the counter value they will sit beside.
  assign w_right     = (w_bit_nxt >= c_SLOT);
  assign w_slot      = w_right ? (w_bit_nxt - c_SLOT) : w_bit_nxt;
  assign w_idx       = c_IDX_W'(c_DATA - w_slot);
  assign w_sample    = w_right ? r_r_held : r_l_held;
  assign w_sdata_nxt = (w_slot != '0) && (w_slot <= c_DATA) && w_sample[w_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active       <= 1'b0;
      r_div_cnt      <= '0;
      r_bit_cnt      <= '0;
      r_l_pend       <= 1'b0;
      r_r_pend       <= 1'b0;
      r_l_pend_data  <= '0;
      r_r_pend_data  <= '0;
      r_l_held       <= '0;
      r_r_held       <= '0;
      r_underrun_cnt <= '0;
      r_bclk         <= 1'b0;
      r_lrclk        <= 1'b0;
      r_sdata        <= 1'b0;
      r_frame_start  <= 1'b0;
      r_underrun     <= 1'b0;
      r_overrun      <= 1'b0;
    end else if (!bus.run) begin
      r_active       <= 1'b0;
      r_div_cnt      <= '0;
      r_bit_cnt      <= '0;
      r_l_pend       <= 1'b0;
      r_r_pend       <= 1'b0;
      r_l_pend_data  <= '0;
      r_r_pend_data  <= '0;
      r_l_held       <= '0;
      r_r_held       <= '0;
      r_underrun_cnt <= '0;
      r_bclk         <= 1'b0;
      r_lrclk        <= 1'b0;
      r_sdata        <= 1'b0;
      r_frame_start  <= 1'b0;
      r_underrun     <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_active      <= 1'b1;
      r_div_cnt     <= w_div_nxt;
      r_bit_cnt     <= w_bit_nxt;
      r_bclk        <= (w_div_nxt >= c_DIV_HALF);
      r_lrclk       <= w_right;
      r_sdata       <= w_sdata_nxt;
      r_frame_start <= (w_div_nxt == '0) && (w_bit_nxt == '0);
      r_underrun    <= w_load && !w_pair;
      r_overrun     <= w_l_over || w_r_over;

      if (w_load && w_pair) begin
        r_l_held <= r_l_pend_data;
        r_r_held <= r_r_pend_data;
        r_l_pend <= 1'b0;
        r_r_pend <= 1'b0;
      end
      if (w_load && !w_pair && (r_underrun_cnt != 8'hFF)) begin
        r_underrun_cnt <= r_underrun_cnt + 8'd1;
      end

      // Later assignments win, so a strobe on the load clk re-arms pend.
      if (bus.l_din_valid) begin
        r_l_pend      <= 1'b1;
        r_l_pend_data <= bus.l_din;
      end
      if (bus.r_din_valid) begin
        r_r_pend      <= 1'b1;
        r_r_pend_data <= bus.r_din;
      end
    end
  end

  assign bus.bclk        = r_bclk;
  assign bus.lrclk       = r_lrclk;
  assign bus.sdata       = r_sdata;
  assign bus.frame_start = r_frame_start;
  assign bus.underrun    = r_underrun;
  assign bus.overrun     = r_overrun;
  assign bus.test_data   = {r_underrun_cnt, 6'(r_bit_cnt), r_l_pend, r_r_pend};
endmodule
`default_nettype wire

// File: tb/tb_i2s_dac_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_i2s_dac_serializer                                           |
// | Function : randomized bench with a frame-level reference model             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_i2s_dac_serializer;
  localparam int FRAME = 512;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic reset_n2 = 1'b0;
  logic chk_en   = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  i2s_dac_serializer_if #(.DATA_BITS(24)) bus ();
  i2s_dac_serializer_if #(.DATA_BITS(24)) bus2 ();

  i2s_dac_serializer #(.BCLK_DIV(8), .SLOT_BITS(32), .DATA_BITS(24)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // Fast-frame instance used only to reach underrun counter saturation.
  i2s_dac_serializer #(.BCLK_DIV(2), .SLOT_BITS(32), .DATA_BITS(24)) dut_sat (
    .clk(clk), .reset_n(reset_n2), .bus(bus2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: m_t is clocks since the frame timing started (-1 = idle).
  int          m_t    = -1;
  bit          m_lp   = 0, m_rp = 0;
  logic [23:0] m_ld   = '0, m_rd = '0, m_hl = '0, m_hr = '0;
  int          m_ucnt = 0;
  bit          m_under = 0, m_over = 0;

  always @(posedge clk or negedge reset_n) begin
    bit load;
    if (!reset_n || !bus.run) begin
      m_t = -1; m_lp = 0; m_rp = 0; m_ld = '0; m_rd = '0;
      m_hl = '0; m_hr = '0; m_ucnt = 0; m_under = 0; m_over = 0;
    end else begin
      load    = (m_t >= 0) && (m_t % FRAME == FRAME - 1);
      m_under = 0;
      m_over  = 0;
      if (load) begin
        if (m_lp && m_rp) begin
          m_hl = m_ld; m_hr = m_rd; m_lp = 0; m_rp = 0;
        end else begin
          m_under = 1;
          if (m_ucnt < 255) m_ucnt++;
        end
      end
      if (bus.l_din_valid) begin
        if (m_lp && !load) m_over = 1;
        m_lp = 1; m_ld = bus.l_din;
      end
      if (bus.r_din_valid) begin
        if (m_rp && !load) m_over = 1;
        m_rp = 1; m_rd = bus.r_din;
      end
      m_t++;
    end
  end

  function automatic logic [5:0] exp_pins();
    int p, b, s;
    logic [23:0] smp;
    logic sd;
    if (m_t < 0) return 6'b0;
    p   = m_t % FRAME;
    b   = p / 8;
    s   = b % 32;
    smp = (b < 32) ? m_hl : m_hr;
    sd  = (s >= 1 && s <= 24) ? smp[24 - s] : 1'b0;
    return {(p % 8) >= 4, b >= 32, sd, p == 0, m_under, m_over};
  endfunction

  function automatic logic [15:0] exp_td();
    int b;
    b = (m_t < 0) ? 0 : (m_t % FRAME) / 8;
    return {8'(m_ucnt), b[5:0], m_lp, m_rp};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("pins", {26'b0, bus.bclk, bus.lrclk, bus.sdata, bus.frame_start,
                        bus.underrun, bus.overrun}, {26'b0, exp_pins()});
      check_eq("test_data", {16'b0, bus.test_data}, {16'b0, exp_td()});
    end
  end

  task automatic strobe(input bit dl, input bit dr, input logic [23:0] l, input logic [23:0] r);
    bus.l_din_valid = dl;
    bus.r_din_valid = dr;
    bus.l_din = dl ? l : 24'($urandom);
    bus.r_din = dr ? r : 24'($urandom);
    @(negedge clk);
    bus.l_din_valid = 1'b0;
    bus.r_din_valid = 1'b0;
    bus.l_din = 24'($urandom);
    bus.r_din = 24'($urandom);
  endtask

  task automatic wait_phase(input int ph);
    int guard = 0;
    while ((m_t < 0 || m_t % FRAME != ph) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check_eq("wait_phase_timeout", 32'(guard), 32'd0);
  endtask

  task automatic main_seq();
    logic [23:0] a, b;
    bus.run = 1'b0; bus.l_din_valid = 1'b0; bus.r_din_valid = 1'b0;
    bus.l_din = '0; bus.r_din = '0;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    bus.run = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;

    wait_phase(100);
    strobe(1, 1, 24'hA5A5A5, 24'h5A5A5A);

    for (int n = 1; n <= 8; n++) begin
      wait_phase(200);
      strobe(1, 1, 24'(n), 24'(-n));
    end

    // Partial pair with an overwrite, completed a frame later.
    a = 24'($urandom); b = 24'($urandom);
    wait_phase(50);  strobe(1, 0, a, '0);
    wait_phase(300); strobe(1, 0, b, '0);
    wait_phase(100); strobe(0, 1, '0, 24'($urandom));

    // Strobes landing on the load clk itself.
    wait_phase(100); strobe(1, 1, 24'hC0FFEE, 24'h0BADF0);
    wait_phase(FRAME - 1); strobe(1, 1, 24'h111111, 24'hEEEEEE);
    wait_phase(100);
    wait_phase(400);

    wait_phase(100); strobe(1, 1, 24'h123456, 24'h654321);
    repeat (4 * FRAME) @(negedge clk);

    repeat (16 * FRAME) begin
      bus.l_din_valid = ($urandom_range(0, 199) == 0);
      bus.r_din_valid = ($urandom_range(0, 199) == 0);
      bus.l_din = 24'($urandom);
      bus.r_din = 24'($urandom);
      @(negedge clk);
    end
    bus.l_din_valid = 1'b0;
    bus.r_din_valid = 1'b0;

    wait_phase(250);
    bus.run = 1'b0;
    repeat (5) @(negedge clk);
    bus.run = 1'b1;
    wait_phase(10); strobe(1, 1, 24'h800001, 24'h7FFFFE);
    repeat (2 * FRAME) @(negedge clk);

    // Asynchronous reset in the middle of a right-slot data bit with bclk high.
    wait_phase(37 * 8 + 5);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_pins", {29'b0, bus.bclk, bus.lrclk, bus.sdata}, 32'd0);
    check_eq("async_rst_td", {16'b0, bus.test_data}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_phase(20); strobe(1, 1, 24'hFEDCBA, 24'h012345);
    repeat (2 * FRAME) @(negedge clk);
    chk_en = 1'b0;
  endtask

  task automatic sat_seq();
    int f;
    bus2.run = 1'b1; bus2.l_din_valid = 1'b0; bus2.r_din_valid = 1'b0;
    bus2.l_din = '0; bus2.r_din = '0;
    repeat (3) @(negedge clk);
    reset_n2 = 1'b1;
    for (int k = 1; k <= 128 * 258; k++) begin
      @(negedge clk);
      check_eq("sat_underrun", {31'b0, bus2.underrun}, {31'b0, (k > 1) && ((k - 1) % 128 == 0)});
      if (k % 128 == 2) begin
        f = (k - 1) / 128;
        check_eq("sat_underrun_cnt", {24'b0, bus2.test_data[15:8]}, 32'((f > 255) ? 255 : f));
      end
    end
  endtask

  initial begin
    fork
      main_seq();
      sat_seq();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire

// File: doc/i2s_dac_serializer.md
Name: i2s_dac_serializer

Overview:
- Downstream stage of the 96 kHz linear interpolator. Captures its per-channel 24-bit outputs and their valid strobes.
- Pairs L and R samples and double-buffers them.
- Serialises each pair as a standard I2S frame (24-bit data, MSB-first, in 32-bit slots, 64 bclk/frame) to the DAC.
- clk is mclk at 49.152 MHz, so one frame equals 512 clk, which locks the serial frame rate to the interpolator's 96 kHz output rate.

Parameters:
- BCLK_DIV, 8, clk cycles per bclk period; must be even and ≥2.
- SLOT_BITS, 32, bclk per channel slot; frame = 2*SLOT_BITS bclk.
- DATA_BITS, 24, sample width; must be < SLOT_BITS.

Ports:
- clk  in  1  master clock (mclk), all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  enable; low synchronously idles the block.
- l_din_valid  in  1  one-clk strobe, l_din valid.
- r_din_valid  in  1  one-clk strobe, r_din valid.
- l_din  in  DATA_BITS  left sample, two's complement.
- r_din  in  DATA_BITS  right sample, two's complement.
- bclk  out  1  I2S bit clock, registered.
- lrclk  out  1  I2S word select: 0 = left, 1 = right; registered.
- sdata  out  1  I2S serial data, registered.
- frame_start  out  1  one-clk pulse on the first clk of each frame.
- underrun  out  1  one-clk pulse when a frame loads without a complete pair.
- overrun  out  1  one-clk pulse when a pending unconsumed sample is overwritten.
- test_data  out  16  {underrun_cnt[7:0], bit_cnt[5:0], l_pend, r_pend}.

Behaviour:
- Reset (async, reset_n=0):
  - div_cnt=0, bit_cnt=0.
  - Pending regs, shift regs and held pair = 0; l_pend=r_pend=0.
  - underrun_cnt=0.
  - All outputs 0.
- run=0: same clearing as reset, but synchronous. Outputs go 0 on the next clk. run rising starts at div_cnt=0, bit_cnt=0.
- Timing counters:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - bit_cnt (0..2*SLOT_BITS-1) increments when div_cnt wraps, and itself wraps at 63.
- bclk: 0 while div_cnt < BCLK_DIV/2, else 1. sdata and lrclk change only on the clk where div_cnt becomes 0 (bclk falling).
- lrclk: 0 for bit_cnt 0..31, 1 for bit_cnt 32..63.
- sdata, with s = bit_cnt mod SLOT_BITS:
  - s=0 → 0 (one-bclk I2S delay).
  - s=1..DATA_BITS → sample bit (DATA_BITS-s), i.e. MSB first.
  - s > DATA_BITS → 0.
  - Left slot uses the held L sample; right slot uses the held R sample.
- Capture:
  - l_din_valid → l_pend_data <= l_din, l_pend <= 1. R is handled identically.
  - If that channel's pend was already 1 (and this is not the load cycle), pulse overrun; the new data overwrites.
  - L and R strobes in the same or different cycles are both legal.
- Load cycle is div_cnt=BCLK_DIV-1 and bit_cnt=63 (the last clk of a frame).
  - If l_pend && r_pend: held pair <= pend data; both pend flags clear.
  - Otherwise: held pair is kept (last pair repeats), pend flags are untouched, underrun pulses the next clk, and underrun_cnt increments (saturates at 255).
  - A partial pair is never split across frames.
- Valid on the load cycle: the load uses the old pend data, and the new strobe is captured afterwards. pend ends at 1 for that channel, with no overrun.
- frame_start pulses on the clk where bit_cnt=0 and div_cnt=0.
- Latency: a pair completed before load cycle N is output as follows:
  - lrclk=0 from N+1.
  - Left MSB on sdata at N+1+BCLK_DIV.
  - Right MSB at N+1+33*BCLK_DIV.
- Arithmetic: no scaling or sign manipulation; bits are transmitted verbatim. Counters are unsigned.

Test Plan:
- Reset behaviour: reset_n low mid-frame with run=1 → bclk=lrclk=sdata=0 immediately, test_data=0. After release with run=1, the first frame_start comes 1 clk later and bclk period = 8 clk.
- Single pair: run=1, L=24'hA5A5A5, R=24'h5A5A5A, strobed together before the first load. Next frame: sdata bits 1..24 = A5A5A5 MSB-first, bits 33..56 = 5A5A5A, all other bits 0. lrclk low for 256 clk, then high for 256 clk.
- Steady stream: strobe a new pair every 512 clk (L=n, R=-n, n=1..8). Each frame carries the matching pair, with no underrun or overrun pulses.
- Underrun: stop strobes after the pair L=24'h123456, R=24'h654321. Every subsequent frame repeats that pair, underrun pulses once per frame, and underrun_cnt reaches 255 and holds.
- Partial pair and overrun: strobe L only, then L again before the load → one overrun pulse. At the load, underrun pulses (no R) and l_pend stays 1. Strobing R then completes the pair with the second L value in the following frame.
- Load collision: strobe L and R exactly on the load-cycle clk while the previous pair is pending → the old pair is loaded, the new pair is sent the next frame, and there is no overrun.
